// File: rtl/rr_pkg.sv
// Shared constants for the RR-interval monitor: FSM encoding, data width and
// default thresholds (all thresholds are in sample ticks).
package rr_pkg;

    localparam int RR_W = 16;

    localparam logic [0:0] ST_FILL  = 1'b0;
    localparam logic [0:0] ST_TRACK = 1'b1;

    localparam int DEF_AVG_DEPTH   = 8;
    localparam int DEF_LOG2_DEPTH  = 3;
    localparam int DEF_REFRACT_RR  = 200;
    localparam int DEF_TACHY_RR    = 600;
    localparam int DEF_BRADY_RR    = 1200;
    localparam int DEF_IRREG_SHIFT = 2;

    // A full window of RR_W-bit intervals summed without overflow.
    function automatic int sum_width(input int log2_depth);
        return RR_W + log2_depth;
    endfunction

endpackage

// File: rtl/rr_interval_monitor_if.sv
// RR-interval stream from the peak/RR front end plus the rhythm-status
// outputs. master = front end / observer, slave = rr_interval_monitor.
interface rr_interval_monitor_if;
    import rr_pkg::*;

    // rr_valid is a one-cycle strobe with no ready: every cycle it is high is
    // one transfer of rr_interval, and the receiver never stalls it.
    logic [RR_W-1:0] rr_interval;
    logic            rr_valid;

    logic [RR_W-1:0] avg_rr;
    logic            avg_valid;
    logic            tachy;
    logic            brady;
    logic            irregular;
    logic            artifact;
    logic [RR_W-1:0] beat_count;
    logic [0:0]      state;

    modport master (
        output rr_interval, rr_valid,
        input  avg_rr, avg_valid, tachy, brady, irregular, artifact,
               beat_count, state
    );

    modport slave (
        input  rr_interval, rr_valid,
        output avg_rr, avg_valid, tachy, brady, irregular, artifact,
               beat_count, state
    );

endinterface

// File: rtl/rr_window_buffer.sv
// AVG_DEPTH-entry ring buffer of accepted intervals with running sum and fill
// count. Unwritten entries read as 0, so subtracting `oldest` is safe in FILL.
module rr_window_buffer
    import rr_pkg::*;
#(
    parameter int AVG_DEPTH  = DEF_AVG_DEPTH,
    parameter int LOG2_DEPTH = DEF_LOG2_DEPTH,
    parameter int SUM_W      = sum_width(LOG2_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [RR_W-1:0]  data_in_i,
    output logic [RR_W-1:0]  oldest_o,
    output logic [SUM_W-1:0] sum_o,
    output logic             full_o
);

    localparam logic [LOG2_DEPTH:0]   FILL_MAX = (LOG2_DEPTH + 1)'(AVG_DEPTH);
    localparam logic [LOG2_DEPTH:0]   FILL_ONE = (LOG2_DEPTH + 1)'(1);
    localparam logic [LOG2_DEPTH-1:0] PTR_ONE  = LOG2_DEPTH'(1);

    logic [RR_W-1:0]       mem_q [AVG_DEPTH];
    logic [LOG2_DEPTH-1:0] wptr_q;
    logic [LOG2_DEPTH:0]   fill_q;
    logic [LOG2_DEPTH:0]   fill_d;
    logic [SUM_W-1:0]      sum_q;

    assign oldest_o = mem_q[wptr_q];
    assign sum_o    = sum_q;

    always_comb begin
        fill_d = fill_q;
        if (push_i && (fill_q != FILL_MAX)) begin
            fill_d = fill_q + FILL_ONE;
        end
    end

    // Reflects this cycle's push so the owner can change state in step.
    assign full_o = (fill_d == FILL_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < AVG_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q <= '0;
            fill_q <= '0;
            sum_q  <= '0;
        end else begin
            fill_q <= fill_d;
            if (push_i) begin
                mem_q[wptr_q] <= data_in_i;
                wptr_q        <= wptr_q + PTR_ONE;
                sum_q         <= sum_q + SUM_W'(data_in_i) - SUM_W'(oldest_o);
            end
        end
    end

endmodule

// File: rtl/rr_interval_monitor.sv
// Receives RR intervals, rejects refractory artefacts, keeps a sliding-window
// average and classifies each accepted beat (tachy / brady / irregular).
module rr_interval_monitor
    import rr_pkg::*;
#(
    parameter int AVG_DEPTH   = DEF_AVG_DEPTH,
    parameter int LOG2_DEPTH  = DEF_LOG2_DEPTH,
    parameter int REFRACT_RR  = DEF_REFRACT_RR,
    parameter int TACHY_RR    = DEF_TACHY_RR,
    parameter int BRADY_RR    = DEF_BRADY_RR,
    parameter int IRREG_SHIFT = DEF_IRREG_SHIFT
) (
    input  logic           clk,
    input  logic           rst,
    rr_interval_monitor_if.slave rr_if
);

    localparam int              SUM_W     = sum_width(LOG2_DEPTH);
    localparam logic [RR_W-1:0] REFRACT_V = RR_W'(REFRACT_RR);
    localparam logic [RR_W-1:0] TACHY_V   = RR_W'(TACHY_RR);
    localparam logic [RR_W-1:0] BRADY_V   = RR_W'(BRADY_RR);

    logic [RR_W-1:0]  rr_data;
    logic             rr_strobe;
    logic             accept;
    logic [RR_W-1:0]  oldest;
    logic [SUM_W-1:0] win_sum;
    logic             win_full;
    logic [SUM_W-1:0] sum_next;
    logic [RR_W-1:0]  dev;
    logic [RR_W-1:0]  thr;

    logic [0:0]      state_q, state_d;
    logic [RR_W-1:0] avg_q, avg_d;
    logic            tachy_q, tachy_d;
    logic            brady_q, brady_d;
    logic            irreg_q, irreg_d;
    logic            artifact_q, artifact_d;
    logic [RR_W-1:0] beat_q, beat_d;

    assign rr_data   = rr_if.rr_interval;
    assign rr_strobe = rr_if.rr_valid;
    assign accept    = rr_strobe && (rr_data != '0) && (rr_data >= REFRACT_V);

    rr_window_buffer #(
        .AVG_DEPTH  (AVG_DEPTH),
        .LOG2_DEPTH (LOG2_DEPTH),
        .SUM_W      (SUM_W)
    ) u_window (
        .clk       (clk),
        .rst       (rst),
        .push_i    (accept),
        .data_in_i (rr_data),
        .oldest_o  (oldest),
        .sum_o     (win_sum),
        .full_o    (win_full)
    );

    assign sum_next = win_sum + SUM_W'(rr_data) - SUM_W'(oldest);

    // Deviation is measured against the average from before this beat.
    assign dev = (rr_data >= avg_q) ? (rr_data - avg_q) : (avg_q - rr_data);
    assign thr = avg_q >> IRREG_SHIFT;

    always_comb begin
        state_d    = state_q;
        avg_d      = avg_q;
        tachy_d    = tachy_q;
        brady_d    = brady_q;
        irreg_d    = irreg_q;
        beat_d     = beat_q;
        artifact_d = rr_strobe && !accept;
        if (accept) begin
            avg_d   = sum_next[SUM_W-1:LOG2_DEPTH];
            tachy_d = (rr_data < TACHY_V);
            brady_d = (rr_data > BRADY_V);
            irreg_d = (state_q == ST_TRACK) && (dev > thr);
            if (beat_q != '1) begin
                beat_d = beat_q + RR_W'(1);
            end
            if ((state_q == ST_FILL) && win_full) begin
                state_d = ST_TRACK;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_FILL;
            avg_q      <= '0;
            tachy_q    <= 1'b0;
            brady_q    <= 1'b0;
            irreg_q    <= 1'b0;
            artifact_q <= 1'b0;
            beat_q     <= '0;
        end else begin
            state_q    <= state_d;
            avg_q      <= avg_d;
            tachy_q    <= tachy_d;
            brady_q    <= brady_d;
            irreg_q    <= irreg_d;
            artifact_q <= artifact_d;
            beat_q     <= beat_d;
        end
    end

    assign rr_if.avg_rr     = avg_q;
    assign rr_if.avg_valid  = (state_q == ST_TRACK);
    assign rr_if.tachy      = tachy_q;
    assign rr_if.brady      = brady_q;
    assign rr_if.irregular  = irreg_q;
    assign rr_if.artifact   = artifact_q;
    assign rr_if.beat_count = beat_q;
    assign rr_if.state      = state_q;

endmodule

// File: tb/tb_rr_interval_monitor.sv
// Directed scoreboard bench for rr_interval_monitor: each strobe pushes its
// hand-computed expected output snapshot; a negedge monitor pops and compares.
module tb_rr_interval_monitor;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rr_interval_monitor_if rr_if ();

    rr_interval_monitor dut (
        .clk   (clk),
        .rst   (rst),
        .rr_if (rr_if.slave)
    );

    // Snapshot layout: {avg_rr[15:0], avg_valid, tachy, brady, irregular, artifact, beat_count[15:0]}
    localparam logic [36:0] M_ALL  = '1;
    localparam logic [36:0] M_PART = {16'h0000, 5'b11101, 16'hFFFF};
    localparam logic [36:0] M_IDLE = {16'h0000, 5'b00001, 16'hFFFF};

    int checks   = 0;
    int failures = 0;

    logic [36:0] exp_q[$];
    logic [36:0] mask_q[$];
    string       name_q[$];

    logic        strobe_seen;
    logic [15:0] last_cnt;
    logic [36:0] act;
    logic [36:0] e_v, m_v;
    string       n_v;

    assign act = {rr_if.avg_rr, rr_if.avg_valid, rr_if.tachy, rr_if.brady,
                  rr_if.irregular, rr_if.artifact, rr_if.beat_count};

    function automatic logic [36:0] pk(input logic [15:0] avg, input logic av,
                                       input logic t, input logic b, input logic i,
                                       input logic a, input logic [15:0] cnt);
        return {avg, av, t, b, i, a, cnt};
    endfunction

    task automatic check(input string name, input logic [36:0] a,
                         input logic [36:0] e, input logic [36:0] m);
        checks++;
        if ((a & m) !== (e & m)) begin
            failures++;
            $display("FAIL %s: got avg=%0d av=%0b t=%0b b=%0b irr=%0b art=%0b cnt=%0d | want avg=%0d av=%0b t=%0b b=%0b irr=%0b art=%0b cnt=%0d (mask %h)",
                     name, a[36:21], a[20], a[19], a[18], a[17], a[16], a[15:0],
                     e[36:21], e[20], e[19], e[18], e[17], e[16], e[15:0], m);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input string name, input logic [15:0] v,
                        input logic [36:0] e, input logic [36:0] m);
        @(posedge clk);
        #2;
        rr_if.rr_valid    = 1'b1;
        rr_if.rr_interval = v;
        exp_q.push_back(e);
        mask_q.push_back(m);
        name_q.push_back(name);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            rr_if.rr_valid = 1'b0;
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(posedge clk or posedge rst) begin
        if (rst) strobe_seen <= 1'b0;
        else     strobe_seen <= rr_if.rr_valid;
    end

    always @(negedge clk) begin
        if (rst) begin
            last_cnt = 16'd0;
        end else if (strobe_seen) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: strobe result with empty expected queue, cnt=%0d",
                         rr_if.beat_count);
            end else begin
                e_v = exp_q.pop_front();
                m_v = mask_q.pop_front();
                n_v = name_q.pop_front();
                check(n_v, act, e_v, m_v);
                last_cnt = e_v[15:0];
            end
        end else begin
            check("idle_hold", act, {16'h0000, 5'b00000, last_cnt}, M_IDLE);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int waited;
        rst               = 1'b1;
        rr_if.rr_valid    = 1'b1;
        rr_if.rr_interval = 16'd1000;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", act, 37'd0, M_ALL);
        @(posedge clk);
        #2;
        rr_if.rr_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;

        for (int k = 1; k <= 8; k++) begin
            send("fill_1000", 16'd1000, pk(16'(125 * k), (k == 8), 1'b0, 1'b0, 1'b0, 1'b0, 16'(k)), M_ALL);
            idle(9);
        end

        send("irreg_1400", 16'd1400, pk(16'd1050, 1, 0, 1, 1, 0, 16'd9), M_ALL);
        idle(3);
        send("regular_1000", 16'd1000, pk(16'd1050, 1, 0, 0, 0, 0, 16'd10), M_ALL);
        idle(3);
        send("artifact_150", 16'd150, pk(16'd1050, 1, 0, 0, 0, 1, 16'd10), M_ALL);
        idle(3);
        send("refract_200", 16'd200, pk(16'd950, 1, 1, 0, 1, 0, 16'd11), M_ALL);
        idle(3);
        send("b2b_1300", 16'd1300, pk(16'd987, 1, 0, 1, 1, 0, 16'd12), M_ALL);
        send("b2b_500", 16'd500, pk(16'd925, 1, 1, 0, 1, 0, 16'd13), M_ALL);
        idle(3);

        for (int k = 0; k < 20; k++) begin
            if (k < 19)
                send("ramp", 16'(1000 + 10 * k), pk(16'd0, 1, 0, 0, 0, 0, 16'(14 + k)), M_PART);
            else
                send("ramp_final", 16'd1190, pk(16'd1155, 1, 0, 0, 0, 0, 16'd33), M_ALL);
            idle(k % 3);
        end
        idle(3);

        for (int k = 0; k < 5; k++) begin
            send("pre_reset_900", 16'd900, pk(16'd0, 1, 0, 0, 0, 0, 16'(34 + k)), M_PART);
            idle(2);
        end

        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_reset", act, 37'd0, M_ALL);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        for (int k = 1; k <= 8; k++) begin
            send("refill_800", 16'd800, pk(16'(100 * k), (k == 8), 1'b0, 1'b0, 1'b0, 1'b0, 16'(k)), M_ALL);
            idle(1);
        end

        send("dev_eq_thr", 16'd1000, pk(16'd825, 1, 0, 0, 0, 0, 16'd9), M_ALL);
        idle(1);
        send("tachy_eq_600", 16'd600, pk(16'd800, 1, 0, 0, 1, 0, 16'd10), M_ALL);
        idle(1);
        send("brady_eq_1200", 16'd1200, pk(16'd850, 1, 0, 0, 1, 0, 16'd11), M_ALL);
        send("art_199", 16'd199, pk(16'd850, 1, 0, 0, 1, 1, 16'd11), M_ALL);
        send("art_zero", 16'd0, pk(16'd850, 1, 0, 0, 1, 1, 16'd11), M_ALL);
        idle(3);

        waited = 0;
        while ((exp_q.size() != 0) && (waited < 50)) begin
            @(posedge clk);
            waited++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected results never appeared, want 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
